instr_feeder: RTL and testbench

Instruction sequencer that drives the processor's RUN/DIN/DONE handshake from a synchronous program ROM. It fetches each 9-bit instruction word and presents it on `din` with a one-cycle `run` pulse. For `mvi` it follows with the immediate word. It then waits for the processor's `done`, advances the program counter, and stops on a halt opcode or at the end of the program. The block sits between the program memory and the processor, replacing the DONE-clocked counter/memory pair with a single-clock initiator.

---
 rtl/instr_feeder.sv | 155 +++++++++++++++
 tb/tb_instr_feeder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_feeder.sv
// Single-clock instruction sequencer: fetches program words from a synchronous ROM and
// drives the processor RUN/DIN/DONE handshake, including the second word of mvi.
module instr_feeder #(
    parameter int          ADDR_W   = 5,
    parameter int          DATA_W   = 9,
    parameter int          PROG_LEN = 32,
    parameter logic [2:0]  OP_MVI   = 3'b001,
    parameter logic [2:0]  OP_HALT  = 3'b111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] din,
    output logic              run,
    input  logic              done,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_IMM,
        S_WAIT,
        S_HALT
    } state_t;

    localparam logic [ADDR_W:0] PROG_END = (ADDR_W+1)'(PROG_LEN);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [7:0]          instr_count_q, instr_count_d;
    logic                past_end_q, past_end_d;
    logic                busy_q, busy_d;
    logic                halted_q, halted_d;

    logic [ADDR_W:0]     pc_inc1;
    logic [ADDR_W:0]     pc_inc2;
    logic [2:0]          opcode;

    // One extra bit so a carry out of pc also counts as running past the program end.
    assign pc_inc1 = {1'b0, pc_q} + (ADDR_W+1)'(1);
    assign pc_inc2 = {1'b0, pc_q} + (ADDR_W+1)'(2);
    assign opcode  = mem_data[DATA_W-1 -: 3];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        mem_addr_d    = mem_addr_q;
        din_d         = din_q;
        instr_count_d = instr_count_q;
        past_end_d    = past_end_q;
        run           = 1'b0;
        din           = din_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d          = '0;
                    instr_count_d = '0;
                    past_end_d    = 1'b0;
                    state_d       = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                din = mem_data;
                if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    run   = 1'b1;
                    din_d = mem_data;
                    if (instr_count_q != 8'hFF) begin
                        instr_count_d = instr_count_q + 8'd1;
                    end
                    if (opcode == OP_MVI) begin
                        state_d = S_IMM;
                    end else begin
                        pc_d       = pc_inc1[ADDR_W-1:0];
                        past_end_d = (pc_inc1 >= PROG_END);
                        state_d    = S_WAIT;
                    end
                end
            end
            S_IMM: begin
                din        = mem_data;
                din_d      = mem_data;
                pc_d       = pc_inc2[ADDR_W-1:0];
                past_end_d = (pc_inc2 >= PROG_END);
                if (done) begin
                    state_d = past_end_d ? S_HALT : S_FETCH;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done) begin
                    state_d = past_end_q ? S_HALT : S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The ROM address is registered, so it is set up on entry to the state that uses it.
        if (state_d == S_FETCH) begin
            mem_addr_d = pc_d;
        end else if (state_d == S_ISSUE) begin
            mem_addr_d = pc_inc1[ADDR_W-1:0];
        end

        busy_d   = (state_d == S_FETCH) || (state_d == S_ISSUE) ||
                   (state_d == S_IMM)   || (state_d == S_WAIT);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            mem_addr_q    <= '0;
            din_q         <= '0;
            instr_count_q <= '0;
            past_end_q    <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mem_addr_q    <= mem_addr_d;
            din_q         <= din_d;
            instr_count_q <= instr_count_d;
            past_end_q    <= past_end_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign pc          = pc_q;
    assign instr_count = instr_count_q;
    assign busy        = busy_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder: synchronous ROM model, optional auto-DONE processor
// model, and hand-computed expectations checked with immediate assertions.
module tb_instr_feeder;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 9;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              start    = 1'b0;
    logic              done_man = 1'b0;
    logic              done_auto = 1'b0;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] din;
    logic              run;
    logic              busy;
    logic              halted;
    logic [7:0]        instr_count;

    logic [DATA_W-1:0] rom [32];

    int errors = 0;
    int checks = 0;

    bit     auto_en  = 1'b0;
    int     done_lat = 1;
    longint cyc      = 0;
    longint due      = -1;

    int                run_cnt       = 0;
    logic              prev_run      = 1'b0;
    logic [DATA_W-1:0] after_run_din = '0;
    logic [DATA_W-1:0] last_run_din  = '0;
    int                r0;

    instr_feeder dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .din         (din),
        .run         (run),
        .done        (done),
        .busy        (busy),
        .halted      (halted),
        .pc          (pc),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) mem_data <= rom[mem_addr];

    assign done = auto_en ? done_auto : done_man;

    // Processor model: done is high for one cycle, done_lat cycles after a run cycle.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        done_auto = auto_en && (cyc == due);
        if (run) due = cyc + done_lat;
    end

    initial forever begin
        @(negedge clk);
        if (prev_run) after_run_din = din;
        if (run) begin
            run_cnt++;
            last_run_din = din;
        end
        prev_run = run;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_halted(input string tag, input int limit);
        int k = 0;
        while (!halted && k < limit) begin
            tick();
            k++;
        end
        chk(tag, 32'(halted), 32'd1);
    endtask

    task automatic fill(input logic [DATA_W-1:0] v);
        for (int i = 0; i < 32; i++) rom[i] = v;
    endtask

    initial begin
        fill(9'o000);
        #1 reset = 1'b1;
        tick();
        tick();
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // mvi R0,5 ; add R0,R0 ; halt with done 3 cycles after run
        fill(9'o000);
        rom[0] = 9'o100; rom[1] = 9'o005; rom[2] = 9'o200; rom[3] = 9'o700;
        auto_en = 1'b1; done_lat = 3;
        r0 = run_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_fetch_busy", 32'(busy), 32'd1);
        chk("t1_fetch_run", 32'(run), 32'd0);
        chk("t1_fetch_addr", 32'(mem_addr), 32'd0);
        tick();
        chk("t1_issue_run", 32'(run), 32'd1);
        chk("t1_issue_din", 32'(din), 32'(9'o100));
        tick();
        chk("t1_imm_run", 32'(run), 32'd0);
        chk("t1_imm_din", 32'(din), 32'(9'o005));
        chk("t1_imm_count", 32'(instr_count), 32'd1);
        wait_halted("t1_halted", 40);
        chk("t1_runs", 32'(run_cnt - r0), 32'd2);
        chk("t1_last_din", 32'(last_run_din), 32'(9'o200));
        chk("t1_count", 32'(instr_count), 32'd2);
        chk("t1_pc", 32'(pc), 32'd3);
        auto_en = 1'b0;

        // single-word mv with done right after run, restarted from HALT
        fill(9'o000);
        rom[2] = 9'o700;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_fetch_addr", 32'(mem_addr), 32'd0);
        chk("t2_fetch_pc", 32'(pc), 32'd0);
        chk("t2_fetch_count", 32'(instr_count), 32'd0);
        tick();
        chk("t2_issue_run", 32'(run), 32'd1);
        chk("t2_issue_addr", 32'(mem_addr), 32'd1);
        tick();
        chk("t2_wait_run", 32'(run), 32'd0);
        done_man = 1'b1;
        tick();
        done_man = 1'b0;
        chk("t2_fetch2_run", 32'(run), 32'd0);
        chk("t2_fetch2_addr", 32'(mem_addr), 32'd1);
        chk("t2_fetch2_pc", 32'(pc), 32'd1);
        tick();
        chk("t2_run_after_done", 32'(run), 32'd1);
        tick();
        done_man = 1'b1;
        tick();
        done_man = 1'b0;
        tick();
        chk("t2_halt_no_run", 32'(run), 32'd0);
        tick();
        chk("t2_halted", 32'(halted), 32'd1);
        chk("t2_count", 32'(instr_count), 32'd2);

        // done during IMM skips WAIT; start ignored while busy
        rom[0] = 9'o100; rom[1] = 9'o055; rom[2] = 9'o200; rom[3] = 9'o700;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t3_issue_run", 32'(run), 32'd1);
        tick();
        chk("t3_imm_din", 32'(din), 32'(9'o055));
        done_man = 1'b1;
        tick();
        done_man = 1'b0;
        chk("t3_fetch_pc", 32'(pc), 32'd2);
        chk("t3_fetch_addr", 32'(mem_addr), 32'd2);
        chk("t3_fetch_busy", 32'(busy), 32'd1);
        tick();
        chk("t3_issue2_run", 32'(run), 32'd1);
        chk("t3_issue2_din", 32'(din), 32'(9'o200));
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_busy_start_pc", 32'(pc), 32'd3);
        chk("t3_busy_start_count", 32'(instr_count), 32'd2);
        chk("t3_busy_start_busy", 32'(busy), 32'd1);
        start = 1'b1;
        done_man = 1'b1;
        tick();
        start = 1'b0;
        done_man = 1'b0;
        chk("t3_done_wins_pc", 32'(pc), 32'd3);
        chk("t3_done_wins_addr", 32'(mem_addr), 32'd3);
        chk("t3_done_wins_count", 32'(instr_count), 32'd2);
        tick();
        tick();
        chk("t3_halted", 32'(halted), 32'd1);

        // start in HALT, then asynchronous reset while in WAIT
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t4_restart_run", 32'(run), 32'd1);
        chk("t4_restart_din", 32'(din), 32'(9'o100));
        tick();
        tick();
        chk("t4_wait_busy", 32'(busy), 32'd1);
        chk("t4_wait_din", 32'(din), 32'(9'o055));
        #3 reset = 1'b1;
        #1;
        chk("t4_arst_mem_addr", 32'(mem_addr), 32'd0);
        chk("t4_arst_din", 32'(din), 32'd0);
        chk("t4_arst_run", 32'(run), 32'd0);
        chk("t4_arst_busy", 32'(busy), 32'd0);
        chk("t4_arst_halted", 32'(halted), 32'd0);
        chk("t4_arst_pc", 32'(pc), 32'd0);
        chk("t4_arst_count", 32'(instr_count), 32'd0);
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_post_fetch_addr", 32'(mem_addr), 32'd0);
        tick();
        chk("t4_post_run", 32'(run), 32'd1);
        chk("t4_post_din", 32'(din), 32'(9'o100));
        auto_en = 1'b1; done_lat = 2;
        wait_halted("t4_post_halted", 40);
        chk("t4_post_count", 32'(instr_count), 32'd2);

        // 32 single-word instructions: pc wraps and the block halts
        fill(9'o000);
        auto_en = 1'b1; done_lat = 1;
        r0 = run_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_halted("t5_halted", 200);
        chk("t5_pc", 32'(pc), 32'd0);
        chk("t5_count", 32'(instr_count), 32'd32);
        chk("t5_runs", 32'(run_cnt - r0), 32'd32);

        // mvi at the last address takes its immediate from address 0
        fill(9'o000);
        rom[0] = 9'o023; rom[31] = 9'o100;
        r0 = run_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_halted("t6_halted", 200);
        chk("t6_imm_din", 32'(after_run_din), 32'(9'o023));
        chk("t6_pc", 32'(pc), 32'd1);
        chk("t6_count", 32'(instr_count), 32'd32);
        chk("t6_runs", 32'(run_cnt - r0), 32'd32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
